// File: rtl/counter_bank_snapshot.sv
// rtl/counter_bank_snapshot.sv - bank of event counters with atomic shadow snapshot and indexed read port
// Live counters absorb registered per-channel increments; snapshots copy every channel into shadow in one edge.
module counter_bank_snapshot #(
  parameter int NUM_CHANNELS  = 4,
  parameter int COUNTER_WIDTH = 16,
  parameter int INCR_WIDTH    = 4,
  parameter int SATURATE      = 0,
  parameter int CLEAR_ON_SNAP = 0,
  localparam int IDX_W        = $clog2(NUM_CHANNELS) + 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             sync_clear,
  input  logic                             enable,
  input  logic [NUM_CHANNELS*INCR_WIDTH-1:0] incr,
  input  logic                             snap_req,
  output logic                             snap_valid,
  input  logic [IDX_W-1:0]                 rd_idx,
  output logic [COUNTER_WIDTH-1:0]         rd_count,
  output logic                             rd_ovf
);

  localparam logic [COUNTER_WIDTH-1:0] ALL_ONES = {COUNTER_WIDTH{1'b1}};

  logic [INCR_WIDTH-1:0]    incr_q       [NUM_CHANNELS];
  logic [INCR_WIDTH-1:0]    incr_d       [NUM_CHANNELS];
  logic [COUNTER_WIDTH-1:0] cnt_q        [NUM_CHANNELS];
  logic [COUNTER_WIDTH-1:0] cnt_d        [NUM_CHANNELS];
  logic [COUNTER_WIDTH:0]   sum          [NUM_CHANNELS];
  logic                     ovf_q        [NUM_CHANNELS];
  logic                     ovf_d        [NUM_CHANNELS];
  logic [COUNTER_WIDTH-1:0] shadow_cnt_q [NUM_CHANNELS];
  logic [COUNTER_WIDTH-1:0] shadow_cnt_d [NUM_CHANNELS];
  logic                     shadow_ovf_q [NUM_CHANNELS];
  logic                     shadow_ovf_d [NUM_CHANNELS];
  logic                     snap_valid_q, snap_valid_d;
  logic [COUNTER_WIDTH-1:0] rd_count_q, rd_count_d;
  logic                     rd_ovf_q, rd_ovf_d;

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      sum[i]          = {1'b0, cnt_q[i]} + (COUNTER_WIDTH+1)'(incr_q[i]);
      incr_d[i]       = enable ? incr[i*INCR_WIDTH +: INCR_WIDTH] : '0;
      shadow_cnt_d[i] = snap_req ? cnt_q[i] : shadow_cnt_q[i];
      shadow_ovf_d[i] = snap_req ? ovf_q[i] : shadow_ovf_q[i];
      // Clearing on snapshot reloads the in-flight increment so no event is dropped.
      if (CLEAR_ON_SNAP != 0 && snap_req) begin
        cnt_d[i] = COUNTER_WIDTH'(incr_q[i]);
        ovf_d[i] = 1'b0;
      end else begin
        ovf_d[i] = ovf_q[i] | sum[i][COUNTER_WIDTH];
        if (SATURATE != 0 && sum[i][COUNTER_WIDTH]) begin
          cnt_d[i] = ALL_ONES;
        end else begin
          cnt_d[i] = sum[i][COUNTER_WIDTH-1:0];
        end
      end
      if (sync_clear) begin
        incr_d[i]       = '0;
        cnt_d[i]        = '0;
        ovf_d[i]        = 1'b0;
        shadow_cnt_d[i] = '0;
        shadow_ovf_d[i] = 1'b0;
      end
    end
    snap_valid_d = snap_req & ~sync_clear;
  end

  // Out-of-range indices match no channel and so read back as zero.
  always_comb begin
    rd_count_d = '0;
    rd_ovf_d   = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_count_d = shadow_cnt_q[i];
        rd_ovf_d   = shadow_ovf_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      incr_q       <= '{default: '0};
      cnt_q        <= '{default: '0};
      ovf_q        <= '{default: 1'b0};
      shadow_cnt_q <= '{default: '0};
      shadow_ovf_q <= '{default: 1'b0};
      snap_valid_q <= 1'b0;
      rd_count_q   <= '0;
      rd_ovf_q     <= 1'b0;
    end else begin
      incr_q       <= incr_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      shadow_cnt_q <= shadow_cnt_d;
      shadow_ovf_q <= shadow_ovf_d;
      snap_valid_q <= snap_valid_d;
      rd_count_q   <= rd_count_d;
      rd_ovf_q     <= rd_ovf_d;
    end
  end

  assign snap_valid = snap_valid_q;
  assign rd_count   = rd_count_q;
  assign rd_ovf     = rd_ovf_q;

endmodule

// File: tb/tb_counter_bank_snapshot.sv
// tb/tb_counter_bank_snapshot.sv - directed bench for wrap, saturate and clear-on-snapshot counter banks
// Three instances share stimulus; each is checked against hand-computed values.
module tb_counter_bank_snapshot;

  logic        clk;
  logic        reset;
  logic        sync_clear;
  logic        enable;
  logic [15:0] incr;
  logic        snap_req;
  logic [2:0]  rd_idx;

  logic        sv_w, sv_s, sv_c;
  logic [15:0] rc_w, rc_s, rc_c;
  logic        ro_w, ro_s, ro_c;

  int n_cmp = 0;
  int n_err = 0;

  counter_bank_snapshot #(.SATURATE(0), .CLEAR_ON_SNAP(0)) dut_w (
    .clk(clk), .reset(reset), .sync_clear(sync_clear), .enable(enable), .incr(incr),
    .snap_req(snap_req), .snap_valid(sv_w), .rd_idx(rd_idx), .rd_count(rc_w), .rd_ovf(ro_w));

  counter_bank_snapshot #(.SATURATE(1), .CLEAR_ON_SNAP(0)) dut_s (
    .clk(clk), .reset(reset), .sync_clear(sync_clear), .enable(enable), .incr(incr),
    .snap_req(snap_req), .snap_valid(sv_s), .rd_idx(rd_idx), .rd_count(rc_s), .rd_ovf(ro_s));

  counter_bank_snapshot #(.SATURATE(0), .CLEAR_ON_SNAP(1)) dut_c (
    .clk(clk), .reset(reset), .sync_clear(sync_clear), .enable(enable), .incr(incr),
    .snap_req(snap_req), .snap_valid(sv_c), .rd_idx(rd_idx), .rd_count(rc_c), .rd_ovf(ro_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap(input string tag);
    snap_req = 1'b1;
    step(1);
    snap_req = 1'b0;
    check(tag, {31'd0, sv_w}, 32'd1);
  endtask

  task automatic clear_all();
    sync_clear = 1'b1;
    step(1);
    sync_clear = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    sync_clear = 1'b0;
    enable     = 1'b1;
    incr       = '0;
    snap_req   = 1'b0;
    rd_idx     = '0;
    #1;
    check("reset_snap_valid", {31'd0, sv_w}, 32'd0);
    check("reset_rd_count",   {16'd0, rc_w}, 32'd0);
    check("reset_rd_ovf",     {31'd0, ro_w}, 32'd0);
    step(2);
    reset = 1'b0;

    // 1: ch0 += 3 for ten cycles
    incr = 16'h0003;
    step(10);
    incr = '0;
    step(1);
    snap("t1_snap_valid");
    check("t1_snap_valid_c", {31'd0, sv_c}, 32'd1);
    rd_idx = 3'd0;
    step(1);
    check("t1_pulse_ends", {31'd0, sv_w}, 32'd0);
    check("t1_count_w", {16'd0, rc_w}, 32'd30);
    check("t1_ovf_w",   {31'd0, ro_w}, 32'd0);
    check("t1_count_s", {16'd0, rc_s}, 32'd30);
    check("t1_count_c", {16'd0, rc_c}, 32'd30);
    rd_idx = 3'd1;
    step(1);
    check("t1_ch1_zero", {16'd0, rc_w}, 32'd0);

    // 2/3: preload 65534, then overflow by 5
    clear_all();
    rd_idx = 3'd0;
    incr = 16'h000F;
    step(4368);
    incr = 16'h000E;
    step(1);
    incr = '0;
    step(1);
    snap("t2_snap_pre");
    step(1);
    check("t2_preload_w", {16'd0, rc_w}, 32'd65534);
    check("t2_preload_ovf", {31'd0, ro_w}, 32'd0);
    incr = 16'h0005;
    step(1);
    incr = '0;
    step(1);
    snap("t2_snap_wrap");
    step(1);
    check("t2_wrap_count", {16'd0, rc_w}, 32'd3);
    check("t2_wrap_ovf",   {31'd0, ro_w}, 32'd1);
    check("t3_sat_count",  {16'd0, rc_s}, 32'd65535);
    check("t3_sat_ovf",    {31'd0, ro_s}, 32'd1);
    incr = 16'h000F;
    step(2);
    incr = '0;
    step(1);
    snap("t2_snap_more");
    step(1);
    check("t2_more_count", {16'd0, rc_w}, 32'd33);
    check("t2_sticky_ovf", {31'd0, ro_w}, 32'd1);
    check("t3_hold_count", {16'd0, rc_s}, 32'd65535);
    check("t3_hold_ovf",   {31'd0, ro_s}, 32'd1);

    // 4: clear-on-snapshot with ch1 += 2 every cycle
    clear_all();
    rd_idx = 3'd1;
    incr = 16'h0020;
    step(5);
    snap("t4_snap1");
    step(1);
    check("t4_pre_s_value", {16'd0, rc_c}, 32'd8);
    check("t4_pulse_ends",  {31'd0, sv_c}, 32'd0);
    snap_req = 1'b1;
    step(1);
    check("t4_b2b_valid1", {31'd0, sv_c}, 32'd1);
    step(1);
    check("t4_b2b_valid2", {31'd0, sv_c}, 32'd1);
    step(1);
    check("t4_b2b_valid3", {31'd0, sv_c}, 32'd1);
    snap_req = 1'b0;
    step(1);
    check("t4_restart", {16'd0, rc_c}, 32'd2);
    incr = '0;
    step(2);
    snap("t4_snap_tail");
    step(1);
    check("t4_tail", {16'd0, rc_c}, 32'd6);
    check("t4_nonclear_total", {16'd0, rc_w}, 32'd22);

    // 5: sync_clear wins over snap_req; disabled increments are ignored
    sync_clear = 1'b1;
    snap_req   = 1'b1;
    step(1);
    sync_clear = 1'b0;
    snap_req   = 1'b0;
    check("t5_no_valid_w", {31'd0, sv_w}, 32'd0);
    check("t5_no_valid_c", {31'd0, sv_c}, 32'd0);
    step(1);
    check("t5_cleared_count", {16'd0, rc_w}, 32'd0);
    check("t5_cleared_ovf",   {31'd0, ro_w}, 32'd0);
    enable = 1'b0;
    incr   = 16'hFFFF;
    step(5);
    snap("t5_snap_dis");
    rd_idx = 3'd0;
    step(1);
    check("t5_dis_ch0", {16'd0, rc_w}, 32'd0);
    rd_idx = 3'd3;
    step(1);
    check("t5_dis_ch3", {16'd0, rc_w}, 32'd0);

    // 6: asynchronous reset mid-count, out-of-range read
    enable = 1'b1;
    incr   = 16'h0001;
    rd_idx = 3'd0;
    step(5);
    snap("t6_snap");
    step(1);
    check("t6_pre_reset", {16'd0, rc_w}, 32'd4);
    snap_req = 1'b1;
    step(1);
    snap_req = 1'b0;
    check("t6_valid_before", {31'd0, sv_w}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_valid", {31'd0, sv_w}, 32'd0);
    check("t6_async_count", {16'd0, rc_w}, 32'd0);
    check("t6_async_ovf",   {31'd0, ro_w}, 32'd0);
    check("t6_async_count_s", {16'd0, rc_s}, 32'd0);
    step(1);
    reset = 1'b0;
    step(3);
    snap("t6_snap_after");
    step(1);
    check("t6_restart_ch0", {16'd0, rc_w}, 32'd2);
    rd_idx = 3'd4;
    step(1);
    check("t6_oor4_count", {16'd0, rc_w}, 32'd0);
    check("t6_oor4_ovf",   {31'd0, ro_w}, 32'd0);
    rd_idx = 3'd7;
    step(1);
    check("t6_oor7_count", {16'd0, rc_w}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
